agc_window_accumulator: RTL and testbench

- Consumer end of the saturate/scale stage: accumulates the per-sample GT/LT threshold flags and 4-bit symmetric magnitudes for one channel over a programmable window of clocks.
- Produces GT count, LT count, their sum and difference, and a sum-of-squares of the reconstructed symmetric magnitude.
- The AGC control loop/register interface reads these results to gain-correct (sum, sum-of-squares) and DC-balance (difference).

---
 rtl/agc_window_accumulator.sv | 232 +++++++++++++++++++++++
 tb/tb_agc_window_accumulator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/agc_window_accumulator.sv
// agc_window_accumulator
// Accumulates the per-lane GT/LT threshold flags and the 4-bit symmetric
// magnitudes of one channel over a programmable window of clocks. At the end
// of the window it publishes:
//   - the GT count and the LT count
//   - their sum and their difference
//   - the sum of (2*abs+1)^2
// The results stay stable until the next accepted start.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   gt_i, lt_i, abs_i   per-lane flags and magnitudes (lane k = abs_i[4k +: 4])
//   en_i                data valid; low masks every lane to zero contribution
//   period_i, start_i   window length in clocks, single-cycle start request
//   busy_o, done_o      window running or draining / results valid (level)
//   ovf_o               sticky saturation flag for the current window
//   gt_count_o, lt_count_o, sum_o, diff_o, sqsum_o   window results
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | after reset, no results yet
// ST_RUN   | sampling inputs, remaining_q counts window clocks down
// ST_DRAIN | pipeline flushing into the accumulators, drain_q counts down
// ST_DONE  | results published and held until the next accepted start
module agc_window_accumulator #(
    parameter int NSAMP       = 8,
    parameter int CNT_BITS    = 24,
    parameter int SQ_BITS     = 36,
    parameter int PERIOD_BITS = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NSAMP-1:0]       gt_i,
    input  logic [NSAMP-1:0]       lt_i,
    input  logic [4*NSAMP-1:0]     abs_i,
    input  logic                   en_i,
    input  logic [PERIOD_BITS-1:0] period_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   ovf_o,
    output logic [CNT_BITS-1:0]    gt_count_o,
    output logic [CNT_BITS-1:0]    lt_count_o,
    output logic [CNT_BITS:0]      sum_o,
    output logic [CNT_BITS:0]      diff_o,
    output logic [SQ_BITS-1:0]     sqsum_o
);

    localparam int POP_W = $clog2(NSAMP + 1);
    localparam int SQL_W = 10;                          // (2*15+1)^2 = 961
    localparam int SQS_W = SQL_W + $clog2(NSAMP) + 1;
    localparam int CW1   = CNT_BITS + 1;
    localparam int SQW1  = SQ_BITS + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                 state_q, state_d;
    logic [PERIOD_BITS-1:0] remaining_q, remaining_d;
    logic [1:0]             drain_q, drain_d;

    logic [NSAMP-1:0]       s1_gt_q, s1_gt_d, s1_lt_q, s1_lt_d, s1_vld_q, s1_vld_d;
    logic [4*NSAMP-1:0]     s1_abs_q, s1_abs_d;
    logic [POP_W-1:0]       s2_gtn_q, s2_gtn_d, s2_ltn_q, s2_ltn_d;
    logic [SQS_W-1:0]       s2_sq_q, s2_sq_d;

    logic [CNT_BITS-1:0]    acc_gt_q, acc_gt_d, acc_lt_q, acc_lt_d;
    logic [SQ_BITS-1:0]     acc_sq_q, acc_sq_d;
    logic                   ovf_q, ovf_d;

    logic [CNT_BITS-1:0]    gt_out_q, gt_out_d, lt_out_q, lt_out_d;
    logic [CNT_BITS:0]      sum_q, sum_d, diff_q, diff_d;
    logic [SQ_BITS-1:0]     sq_out_q, sq_out_d;

    logic                   accept;
    logic [4:0]             lane_odd;
    logic [SQL_W-1:0]       lane_sq;
    logic [CW1-1:0]         gt_sum, lt_sum;
    logic [SQW1-1:0]        sq_sum;

    assign accept = start_i && (period_i != '0) &&
                    (state_q == ST_IDLE || state_q == ST_DONE);

    // Control FSM and result publication
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        drain_d     = drain_q;
        gt_out_d    = gt_out_q;
        lt_out_d    = lt_out_q;
        sum_d       = sum_q;
        diff_d      = diff_q;
        sq_out_d    = sq_out_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d     = ST_RUN;
                    remaining_d = period_i;
                    gt_out_d    = '0;
                    lt_out_d    = '0;
                    sum_d       = '0;
                    diff_d      = '0;
                    sq_out_d    = '0;
                end
            end
            ST_RUN: begin
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == PERIOD_BITS'(1)) begin
                    state_d = ST_DRAIN;
                    drain_d = 2'd3;
                end
            end
            ST_DRAIN: begin
                // The accumulators settle while drain_q is still counting.
                // Publishing one clock after it reaches zero gives a
                // start-to-done latency of period + 4.
                if (drain_q == 2'd0) begin
                    state_d  = ST_DONE;
                    gt_out_d = acc_gt_q;
                    lt_out_d = acc_lt_q;
                    sq_out_d = acc_sq_q;
                    sum_d    = CW1'(acc_gt_q) + CW1'(acc_lt_q);
                    diff_d   = CW1'(acc_gt_q) - CW1'(acc_lt_q);
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 1: masked input capture.
    // Lanes captured outside RUN are forced invalid, so the pipeline carries
    // zeros whenever no window is sampling.
    always_comb begin
        s1_vld_d = {NSAMP{en_i && (state_q == ST_RUN)}};
        s1_gt_d  = gt_i & s1_vld_d;
        s1_lt_d  = lt_i & s1_vld_d;
        s1_abs_d = '0;
        for (int k = 0; k < NSAMP; k++) begin
            if (s1_vld_d[k]) s1_abs_d[4*k +: 4] = abs_i[4*k +: 4];
        end
    end

    // Stage 2: popcounts and the sum of squares across lanes.
    // An invalid lane must add 0 to the square sum, not (2*0+1)^2 = 1.
    always_comb begin
        s2_gtn_d = '0;
        s2_ltn_d = '0;
        s2_sq_d  = '0;
        lane_odd = '0;
        lane_sq  = '0;
        for (int k = 0; k < NSAMP; k++) begin
            s2_gtn_d = s2_gtn_d + POP_W'(s1_gt_q[k]);
            s2_ltn_d = s2_ltn_d + POP_W'(s1_lt_q[k]);
            lane_odd = {s1_abs_q[4*k +: 4], 1'b1};
            lane_sq  = SQL_W'(lane_odd) * SQL_W'(lane_odd);
            if (s1_vld_q[k]) s2_sq_d = s2_sq_d + SQS_W'(lane_sq);
        end
    end

    // Stage 3: saturating accumulators
    always_comb begin
        gt_sum = {1'b0, acc_gt_q} + CW1'(s2_gtn_q);
        lt_sum = {1'b0, acc_lt_q} + CW1'(s2_ltn_q);
        sq_sum = {1'b0, acc_sq_q} + SQW1'(s2_sq_q);
        if (accept) begin
            acc_gt_d = '0;
            acc_lt_d = '0;
            acc_sq_d = '0;
            ovf_d    = 1'b0;
        end else begin
            acc_gt_d = gt_sum[CNT_BITS] ? '1 : gt_sum[CNT_BITS-1:0];
            acc_lt_d = lt_sum[CNT_BITS] ? '1 : lt_sum[CNT_BITS-1:0];
            acc_sq_d = sq_sum[SQ_BITS]  ? '1 : sq_sum[SQ_BITS-1:0];
            ovf_d    = ovf_q | gt_sum[CNT_BITS] | lt_sum[CNT_BITS] | sq_sum[SQ_BITS];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            drain_q     <= '0;
            s1_gt_q     <= '0;
            s1_lt_q     <= '0;
            s1_vld_q    <= '0;
            s1_abs_q    <= '0;
            s2_gtn_q    <= '0;
            s2_ltn_q    <= '0;
            s2_sq_q     <= '0;
            acc_gt_q    <= '0;
            acc_lt_q    <= '0;
            acc_sq_q    <= '0;
            ovf_q       <= 1'b0;
            gt_out_q    <= '0;
            lt_out_q    <= '0;
            sum_q       <= '0;
            diff_q      <= '0;
            sq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            drain_q     <= drain_d;
            s1_gt_q     <= s1_gt_d;
            s1_lt_q     <= s1_lt_d;
            s1_vld_q    <= s1_vld_d;
            s1_abs_q    <= s1_abs_d;
            s2_gtn_q    <= s2_gtn_d;
            s2_ltn_q    <= s2_ltn_d;
            s2_sq_q     <= s2_sq_d;
            acc_gt_q    <= acc_gt_d;
            acc_lt_q    <= acc_lt_d;
            acc_sq_q    <= acc_sq_d;
            ovf_q       <= ovf_d;
            gt_out_q    <= gt_out_d;
            lt_out_q    <= lt_out_d;
            sum_q       <= sum_d;
            diff_q      <= diff_d;
            sq_out_q    <= sq_out_d;
        end
    end

    assign busy_o     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o     = (state_q == ST_DONE);
    assign ovf_o      = ovf_q;
    assign gt_count_o = gt_out_q;
    assign lt_count_o = lt_out_q;
    assign sum_o      = sum_q;
    assign diff_o     = diff_q;
    assign sqsum_o    = sq_out_q;

endmodule

// File: tb/tb_agc_window_accumulator.sv
// Directed bench for agc_window_accumulator.
// Two instances share one stimulus stream:
//   - dut   uses the default 24-bit counters.
//   - dut_s uses 4-bit counters, so the saturation path can be exercised.
module tb_agc_window_accumulator;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  gt_i, lt_i;
    logic [31:0] abs_i;
    logic        en_i;
    logic [23:0] period_i;
    logic        start_i;

    logic        busy_o, done_o, ovf_o;
    logic [23:0] gt_count_o, lt_count_o;
    logic [24:0] sum_o, diff_o;
    logic [35:0] sqsum_o;

    logic        s_busy_o, s_done_o, s_ovf_o;
    logic [3:0]  s_gt_count_o, s_lt_count_o;
    logic [4:0]  s_sum_o, s_diff_o;
    logic [35:0] s_sqsum_o;

    int vec_cnt = 0;
    int err_cnt = 0;
    int lat;

    always #5 clk_i = ~clk_i;

    agc_window_accumulator dut (
        .clk_i(clk_i), .rst_i(rst_i), .gt_i(gt_i), .lt_i(lt_i), .abs_i(abs_i),
        .en_i(en_i), .period_i(period_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o),
        .gt_count_o(gt_count_o), .lt_count_o(lt_count_o),
        .sum_o(sum_o), .diff_o(diff_o), .sqsum_o(sqsum_o)
    );

    agc_window_accumulator #(.CNT_BITS(4)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .gt_i(gt_i), .lt_i(lt_i), .abs_i(abs_i),
        .en_i(en_i), .period_i(period_i), .start_i(start_i),
        .busy_o(s_busy_o), .done_o(s_done_o), .ovf_o(s_ovf_o),
        .gt_count_o(s_gt_count_o), .lt_count_o(s_lt_count_o),
        .sum_o(s_sum_o), .diff_o(s_diff_o), .sqsum_o(s_sqsum_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp)
        else begin
            err_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept a window, then clock until done_o rises (bounded).
    // en_i is low for window cycles off_lo..off_hi.
    // When poke is set, a start with period 5 is pulsed in window cycle 3.
    task automatic run_window(input logic [23:0] p, input int off_lo, input int off_hi,
                              input bit poke, output int n);
        period_i = p;
        start_i  = 1'b1;
        en_i     = 1'b1;
        tick();
        start_i  = 1'b0;
        check("busy_after_start", busy_o, 1);
        check("done_cleared_on_start", done_o, 0);
        n = 0;
        while (!done_o && n < 400) begin
            en_i = !((n + 1) >= off_lo && (n + 1) <= off_hi);
            if (poke && n == 2) begin
                start_i  = 1'b1;
                period_i = 24'd5;
            end else begin
                start_i  = 1'b0;
            end
            tick();
            n++;
        end
        start_i = 1'b0;
        en_i    = 1'b1;
    endtask

    initial begin
        rst_i = 1'b1; gt_i = '0; lt_i = '0; abs_i = '0; en_i = 1'b0;
        period_i = '0; start_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_gt", gt_count_o, 0);
        check("rst_sqsum", sqsum_o, 0);

        // Window 1: period 4, all GT, full-scale magnitudes
        gt_i = 8'hFF; lt_i = 8'h00; abs_i = 32'hFFFF_FFFF;
        run_window(24'd4, 1000, -1, 1'b0, lat);
        check("w1_latency", lat, 8);
        check("w1_gt", gt_count_o, 32);
        check("w1_lt", lt_count_o, 0);
        check("w1_sum", sum_o, 32);
        check("w1_diff", diff_o, 32);
        check("w1_sqsum", sqsum_o, 30752);
        check("w1_ovf", ovf_o, 0);
        check("w1_busy", busy_o, 0);
        check("w1_small_gt_clamp", s_gt_count_o, 15);
        check("w1_small_ovf", s_ovf_o, 1);

        // Window 2: period 10, balanced flags, zero magnitude.
        // A start pulsed in RUN must be ignored.
        gt_i = 8'h0F; lt_i = 8'hF0; abs_i = 32'h0;
        run_window(24'd10, 1000, -1, 1'b1, lat);
        check("w2_latency", lat, 14);
        check("w2_gt", gt_count_o, 40);
        check("w2_lt", lt_count_o, 40);
        check("w2_sum", sum_o, 80);
        check("w2_diff", diff_o, 0);
        check("w2_sqsum", sqsum_o, 80);

        // A start with period 0 while in DONE must be ignored
        period_i = 24'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        check("p0_done_held", done_o, 1);
        check("p0_busy", busy_o, 0);
        check("p0_gt_held", gt_count_o, 40);
        check("p0_sqsum_held", sqsum_o, 80);

        // Window 3: en_i low in window cycles 2-3
        gt_i = 8'h01; lt_i = 8'h00; abs_i = 32'h3333_3333;
        run_window(24'd6, 2, 3, 1'b0, lat);
        check("w3_latency", lat, 10);
        check("w3_gt", gt_count_o, 4);
        check("w3_diff", diff_o, 4);
        check("w3_sqsum", sqsum_o, 1568);

        // Window 4: saturation of the narrow instance
        gt_i = 8'hFF; lt_i = 8'h00; abs_i = 32'h0;
        run_window(24'd3, 1000, -1, 1'b0, lat);
        check("w4_latency", lat, 7);
        check("w4_gt", gt_count_o, 24);
        check("w4_ovf", ovf_o, 0);
        check("w4_small_gt", s_gt_count_o, 15);
        check("w4_small_ovf", s_ovf_o, 1);
        check("w4_small_sum", s_sum_o, 15);
        check("w4_small_diff", s_diff_o, 15);
        check("w4_small_sqsum", s_sqsum_o, 24);

        // Reset two cycles into a long window
        gt_i = 8'hFF; lt_i = 8'h0F; abs_i = 32'hFFFF_FFFF;
        period_i = 24'd100; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_gt", gt_count_o, 0);
        check("mid_rst_lt", lt_count_o, 0);
        check("mid_rst_sqsum", sqsum_o, 0);
        check("mid_rst_ovf", ovf_o, 0);

        // Fresh single-cycle window after reset
        gt_i = 8'h03; lt_i = 8'h01; abs_i = 32'h1111_1111;
        run_window(24'd1, 1000, -1, 1'b0, lat);
        check("w6_latency", lat, 5);
        check("w6_gt", gt_count_o, 2);
        check("w6_lt", lt_count_o, 1);
        check("w6_sum", sum_o, 3);
        check("w6_diff", diff_o, 1);
        check("w6_sqsum", sqsum_o, 72);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
